// File: rtl/handshake_sync_tx_if.sv
// Bus bundle for the sending side of a 4-phase req/ack CDC link.
// master = transmitter (handshake_sync_tx), slave = source/receiver environment.
interface handshake_sync_tx_if #(
  parameter int DATA_W = 8
);
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_ready;
  logic              ack_b;
  logic              req_a;
  logic [DATA_W-1:0] data_a;
  logic              done;
  logic              err_clr;
  logic              timeout_err;

  modport master (
    input  src_valid, src_data, ack_b, err_clr,
    output src_ready, req_a, data_a, done, timeout_err
  );

  modport slave (
    output src_valid, src_data, ack_b, err_clr,
    input  src_ready, req_a, data_a, done, timeout_err
  );
endinterface

// File: rtl/handshake_sync_tx.sv
// 4-phase req/ack transmitter: takes a word via valid/ready, holds it on data_a
// under req_a, synchronises the receiver's ack and flags stalled phases.
module handshake_sync_tx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                clk_a,
  input  logic                rst_a,
  handshake_sync_tx_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    REL
  } state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
    end
  endgenerate

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   req_q;
  logic                   done_q;
  logic                   err_q;
  logic [DATA_W-1:0]      data_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;

  logic ack_sync;
  logic src_ready;
  logic accept;
  logic in_phase;
  logic advance;
  logic err_set;

  assign ack_sync  = ack_sync_q[SYNC_STAGES-1];
  assign src_ready = (state_q == IDLE) && !ack_sync;
  assign accept    = src_ready && bus.src_valid;
  assign in_phase  = (state_q == REQ) || (state_q == REL);

  always_comb begin
    advance = 1'b0;
    case (state_q)
      IDLE:    advance = accept;
      REQ:     advance = ack_sync;
      REL:     advance = !ack_sync;
      default: advance = 1'b1;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (advance || !in_phase) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Fire only on the cycle the count reaches the limit so err_clr can take
  // effect while the counter sits saturated in a stalled phase.
  assign err_set = (TIMEOUT != 0) && in_phase && !advance &&
                   (cnt_q != CNT_MAX) && (cnt_d == CNT_MAX);

  always_ff @(posedge clk_a) begin
    if (rst_a) begin
      state_q    <= IDLE;
      ack_sync_q <= '0;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
      cnt_q      <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bus.ack_b};
      cnt_q      <= cnt_d;
      done_q     <= 1'b0;

      if (err_set) begin
        err_q <= 1'b1;
      end else if (bus.err_clr) begin
        err_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (accept) begin
            data_q  <= bus.src_data;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (ack_sync) begin
            req_q   <= 1'b0;
            state_q <= REL;
          end
        end
        REL: begin
          if (!ack_sync) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.src_ready   = src_ready;
  assign bus.req_a       = req_q;
  assign bus.data_a      = data_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_handshake_sync_tx.sv
// Bench for handshake_sync_tx: directed stimulus with a queue-based scoreboard;
// a receiver model echoes req_a back on ack_b three cycles later.
module tb_handshake_sync_tx;
  localparam int DW = 8;
  localparam int SS = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  handshake_sync_tx_if #(.DATA_W(DW)) bus ();

  handshake_sync_tx #(
    .DATA_W     (DW),
    .SYNC_STAGES(SS),
    .TIMEOUT    (TO)
  ) dut (
    .clk_a(clk),
    .rst_a(rst),
    .bus  (bus.master)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];

  // Receiver model: ack follows req after 3 cycles unless forced
  logic [2:0] req_dly  = '0;
  logic       ack_auto = 1'b1;
  logic       ack_force = 1'b0;
  always @(posedge clk) req_dly <= {req_dly[1:0], bus.req_a};
  assign bus.ack_b = ack_auto ? req_dly[2] : ack_force;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops expected word on each req_a rise, checks data_a holds it
  logic          mon_en    = 1'b0;
  logic          rst_seen  = 1'b0;
  logic          req_prev  = 1'b0;
  logic          done_prev = 1'b0;
  logic [DW-1:0] cur       = '0;
  int            done_cnt  = 0;

  always @(posedge clk) rst_seen <= rst;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_seen) begin
        cur       = '0;
        req_prev  = 1'b0;
        done_prev = 1'b0;
      end else begin
        if (bus.req_a && !req_prev) begin
          if (exp_q.size() == 0) check("unexpected_accept", 32'(exp_q.size()), 1);
          else cur = exp_q.pop_front();
        end
        check("data_a_hold", 32'(bus.data_a), 32'(cur));
        if (bus.done) begin
          done_cnt++;
          check("done_width", 32'(done_prev), 0);
          check("done_req_low", 32'(bus.req_a), 0);
        end
        req_prev  = bus.req_a;
        done_prev = bus.done;
      end
    end
  end

  task automatic offer(input logic [DW-1:0] w);
    int i = 0;
    bus.src_valid = 1'b1;
    bus.src_data  = w;
    while (!bus.src_ready && i < 40) begin
      @(negedge clk);
      i++;
    end
    check("accepted", 32'(bus.src_ready), 1);
    if (bus.src_ready) begin
      exp_q.push_back(w);
      @(negedge clk);
    end
    bus.src_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int cyc);
    cyc = 0;
    while (!bus.done && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", 32'(bus.done), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bus.src_valid = 1'b0;
    bus.src_data  = '0;
    bus.err_clr   = 1'b0;

    // Reset state
    repeat (5) @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    check("rst_req_a", 32'(bus.req_a), 0);
    check("rst_data_a", 32'(bus.data_a), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_timeout_err", 32'(bus.timeout_err), 0);
    check("rst_src_ready", 32'(bus.src_ready), 1);

    // 1. Single transfer: accept E0, ack up E3, req down E6, ack down E9, done E12
    offer(8'hA5);
    check("t1_req_after_accept", 32'(bus.req_a), 1);
    check("t1_data_after_accept", 32'(bus.data_a), 32'h A5);
    wait_done(40, cyc);
    check("t1_done_latency", 32'(cyc), 12);
    check("t1_ready_at_done", 32'(bus.src_ready), 1);
    @(negedge clk);
    check("t1_done_cleared", 32'(bus.done), 0);
    check("t1_done_count", 32'(done_cnt), 1);

    // 2. Back-to-back with valid held
    offer(8'h01);
    offer(8'h02);
    offer(8'h03);
    wait_done(40, cyc);
    @(negedge clk);
    check("t2_done_count", 32'(done_cnt), 4);
    check("t2_queue_empty", 32'(exp_q.size()), 0);
    check("t2_last_data", 32'(bus.data_a), 32'h03);

    // 3. src_data churns while busy; valid dropped in the done cycle
    offer(8'h5C);
    cyc = 0;
    while (!bus.done && cyc < 40) begin
      bus.src_valid = 1'b1;
      bus.src_data  = DW'($urandom);
      @(negedge clk);
      cyc++;
    end
    bus.src_valid = 1'b0;
    check("t3_done_seen", 32'(bus.done), 1);
    @(negedge clk);
    check("t3_data_held", 32'(bus.data_a), 32'h5C);
    check("t3_queue_empty", 32'(exp_q.size()), 0);
    check("t3_done_count", 32'(done_cnt), 5);

    // 4. Timeout in REQ, clear, then complete late
    ack_auto  = 1'b0;
    ack_force = 1'b0;
    offer(8'h3C);
    repeat (15) @(negedge clk);
    check("t4_err_before_limit", 32'(bus.timeout_err), 0);
    @(negedge clk);
    check("t4_err_at_limit", 32'(bus.timeout_err), 1);
    check("t4_req_still_high", 32'(bus.req_a), 1);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check("t4_err_cleared", 32'(bus.timeout_err), 0);
    repeat (3) @(negedge clk);
    check("t4_err_stays_clear", 32'(bus.timeout_err), 0);
    check("t4_req_waiting", 32'(bus.req_a), 1);
    ack_force = 1'b1;
    cyc = 0;
    while (bus.req_a && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("t4_ack_to_req_fall", 32'(cyc), 3);
    ack_force = 1'b0;
    wait_done(10, cyc);
    check("t4_ack_fall_to_done", 32'(cyc), 3);
    @(negedge clk);
    ack_auto = 1'b1;
    check("t4_done_count", 32'(done_cnt), 6);
    check("t4_err_after_done", 32'(bus.timeout_err), 0);

    // 5. Reset while req_a=1; unreset receiver returns a stale ack pulse
    offer(8'h77);
    check("t5_req_before_rst", 32'(bus.req_a), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_req_after_rst", 32'(bus.req_a), 0);
    check("t5_data_after_rst", 32'(bus.data_a), 0);
    check("t5_ready_after_rst", 32'(bus.src_ready), 1);
    repeat (4) @(negedge clk);
    check("t5_ready_blocked_stale", 32'(bus.src_ready), 0);
    @(negedge clk);
    check("t5_ready_recovered", 32'(bus.src_ready), 1);
    repeat (4) @(negedge clk);
    check("t5_no_req", 32'(bus.req_a), 0);
    check("t5_done_count", 32'(done_cnt), 6);

    // 6. Stale high ack in IDLE blocks acceptance
    ack_auto  = 1'b0;
    ack_force = 1'b1;
    repeat (3) @(negedge clk);
    bus.src_valid = 1'b1;
    bus.src_data  = 8'h99;
    repeat (4) begin
      @(negedge clk);
      check("t6_ready_low", 32'(bus.src_ready), 0);
    end
    ack_force = 1'b0;
    cyc = 0;
    while (!bus.src_ready && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_ack_fall_to_ready", 32'(cyc), 2);
    if (bus.src_ready) exp_q.push_back(8'h99);
    @(negedge clk);
    bus.src_valid = 1'b0;
    ack_auto = 1'b1;
    wait_done(40, cyc);
    @(negedge clk);
    check("t6_done_count", 32'(done_cnt), 7);
    check("t6_queue_empty", 32'(exp_q.size()), 0);
    check("t6_data", 32'(bus.data_a), 32'h99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
